banked_sync_mem: RTL and testbench
==================================

Name: banked_sync_mem

Overview:
- Clocked, parametrised successor to the CPU's two-region behavioural memory.
- Provides NUM_BANKS byte-addressable, big-endian banks, each mapped at its own base address.
- Uses a valid/ready request and response handshake with configurable wait states and per-byte write enables.
- Out-of-range accesses return an error response; the simulation does not terminate.
- Sits between the CPU memory port and the instruction/data/exception images.

Parameters:
- NUM_BANKS, 2, number of mapped regions (1..4).
- BANK_BYTES, 256, bytes per bank; power of two, at least 4.
- BANK0_BASE, 32'h0000_0000, base address of bank 0.
- BANK1_BASE, 32'h8000_0000, base address of bank 1 (BANK2/3_BASE follow at 32'h4000_0000 and 32'hC000_0000).
- WAIT_CYCLES, 0, extra cycles between request accept and response (0..15).
- INIT_FILE0, "", $readmemh image for bank 0; empty means no load (INIT_FILE1..3 likewise).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored (word aligned).
- req_wdata  in  32  write data; [31:24] goes to the lowest byte address.
- req_be  in  4  byte enables; be[3] maps to wdata[31:24].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  read data, big-endian; 0 for writes and errors.
- rsp_err  out  1  address matched no bank.

Behaviour:
- Reset values (applied when reset is sampled high):
  - State = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Bank arrays are not reset.
- Address decode:
  - Bank k is hit when req_addr[31:log2(BANK_BYTES)] equals BANKk_BASE[31:log2(BANK_BYTES)].
  - Offset = req_addr[log2(BANK_BYTES)-1:2] concatenated with 2'b00.
  - First matching bank wins. No match sets err = 1.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, the request is accepted. Address, write flag, data and byte enables are latched, and the bank is decoded.
    - Write with a hit: enabled bytes are written on the accept edge; disabled bytes are unchanged.
    - Read with a hit: the word is captured on the accept edge.
    - Error: no array access occurs.
    - WAIT_CYCLES = 0: go to RESP. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready = 0. The counter decrements each cycle; when it reaches 1, go to RESP.
  - RESP: rsp_valid = 1, and rsp_rdata and rsp_err are held stable. req_ready = 0. On rsp_ready, go to IDLE and clear rsp_valid.
- Latency: a request accepted at edge N gives rsp_valid high after edge N+1+WAIT_CYCLES.
- Throughput: at most one transaction in flight. req_ready stays low from accept until the response handshake completes. There is no back-to-back overlap; the next accept happens at the earliest one cycle after the response handshake.
- Read data reflects array contents at the accept edge; a write cannot overlap a read.
- If req_be = 0 on a write, the write completes normally with no change to memory and rsp_err = 0.
- Reset in WAIT or RESP: the transaction is abandoned, state returns to IDLE, and no response is issued. A write already committed at the accept edge stays in memory.
- req_valid sampled while not ready is ignored; the requester must hold its request.

Optional Feature:
- MEM_ERR_LOG_EN defined:
  - Adds outputs err_sticky (1 bit) and err_addr (32 bits), both reset to 0.
  - On the first erroring accept after reset, err_sticky is set to 1 and err_addr captures the full req_addr.
  - Later errors do not overwrite either value until reset.
  - Each error also issues a $display with the address.
- Without the macro: neither port exists and there is no message.

Decomposition:
- Package mem_pkg holds:
  - State enum {IDLE, WAIT, RESP}.
  - Wait counter width constant (4).
  - Big-endian lane mapping constants.
  - Helper function for the bank-hit compare.
- Sub-module mem_bank holds one BANK_BYTES byte array with:
  - Combinational big-endian word read at an offset.
  - Byte-enabled write on clk.
  - Optional $readmemh from an INIT_FILE parameter.
- banked_sync_mem instantiates NUM_BANKS mem_bank instances, plus the decode logic and FSM.

Test Plan:
- WAIT_CYCLES = 0: write 32'hDEADBEEF to 32'h0000_0010 with be = 4'hF, then read the same address. rsp_valid appears one cycle after accept with rdata = 32'hDEADBEEF and rsp_err = 0; byte 0x10 = 8'hDE.
- Write 32'h11223344 with be = 4'b0101 over a word holding 32'hAABBCCDD at 32'h8000_0004, then read it back. Result is 32'hAA22CC44 from bank 1; bank 0 offset 4 is unchanged.
- WAIT_CYCLES = 3 with rsp_ready held low for 5 cycles. rsp_valid rises 4 cycles after accept, and data stays stable until rsp_ready. req_ready stays 0 throughout and returns to 1 the cycle after the handshake.
- Read from 32'h1234_0000. Result is rsp_err = 1, rdata = 0, and the simulation continues. With MEM_ERR_LOG_EN: err_sticky = 1 and err_addr = 32'h1234_0000; a second error at 32'h5000_0000 leaves err_addr unchanged.
- Read at 32'h0000_00FE (unaligned). Returns the word at offset 0xFC, big-endian.
- Assert reset in WAIT during a write with WAIT_CYCLES = 5. No rsp_valid is issued, req_ready = 1 the cycle after reset, and a later read shows the written data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked synchronous memory.
// Holds the FSM state type, wait-counter width, lane mapping and bank decode.
// Pure declarations; no logic of its own.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait counter holds WAIT_CYCLES (0..15).
  localparam int CNT_W = 4;

  // Big-endian lanes: byte at word offset i lives on data lane (LANE_OF_BYTE0 - i),
  // i.e. bits [8*(3-i) +: 8], and is enabled by be[3-i].
  localparam int WORD_BYTES    = 4;
  localparam int LANE_OF_BYTE0 = 3;

  // A bank is hit when all address bits above the in-bank offset match its base.
  function automatic logic bank_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned lsb);
    logic [31:0] diff;
    diff = (addr ^ base) >> lsb;
    return (diff == 32'd0);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One byte-addressed bank: combinational big-endian word read, byte-enabled write.
// Read is zero-latency; write commits on the rising clock edge.
// No flow control; the parent decides when we is asserted.
module mem_bank
  import mem_pkg::*;
#(
  parameter int    BANK_BYTES = 256,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(BANK_BYTES)-1:0] offset,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    be,
  output logic [31:0]                   rdata
);

  localparam int OFF_W = $clog2(BANK_BYTES);

  logic [7:0]       mem_q [BANK_BYTES];
  logic [OFF_W-1:0] word_ofs;

  // Low two offset bits are ignored: every access is to the containing word.
  assign word_ofs = offset & ~OFF_W'(3);

  // Assemble the word with the lowest byte address on the most significant lane.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata[8*(LANE_OF_BYTE0-i) +: 8] = mem_q[word_ofs + OFF_W'(i)];
    end
  end

  // Write only the bytes whose enable is set; others keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[LANE_OF_BYTE0-i]) begin
          mem_q[word_ofs + OFF_W'(i)] <= wdata[8*(LANE_OF_BYTE0-i) +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/banked_sync_mem.sv
// Banked big-endian memory with valid/ready request and response; optional error log under MEM_ERR_LOG_EN.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept edge.
// One transaction in flight; req_ready low from accept until the response handshake.
module banked_sync_mem
  import mem_pkg::*;
#(
  parameter int          NUM_BANKS   = 2,
  parameter int          BANK_BYTES  = 256,
  parameter logic [31:0] BANK0_BASE  = 32'h0000_0000,
  parameter logic [31:0] BANK1_BASE  = 32'h8000_0000,
  parameter logic [31:0] BANK2_BASE  = 32'h4000_0000,
  parameter logic [31:0] BANK3_BASE  = 32'hC000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter string       INIT_FILE0  = "",
  parameter string       INIT_FILE1  = "",
  parameter string       INIT_FILE2  = "",
  parameter string       INIT_FILE3  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef MEM_ERR_LOG_EN
  ,
  output logic        err_sticky,
  output logic [31:0] err_addr
`endif
);

  localparam int          OFF_W     = $clog2(BANK_BYTES);
  localparam logic [31:0] BASES [4] = '{BANK0_BASE, BANK1_BASE, BANK2_BASE, BANK3_BASE};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               accept;
  logic               hit;
  logic [NUM_BANKS-1:0] sel_oh;
  logic [31:0]        hit_rdata;
  logic [31:0]        bank_rdata [NUM_BANKS];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_ready & req_valid;

  // Decode: scan from the highest bank down so the lowest-numbered match wins.
  always_comb begin
    hit       = 1'b0;
    sel_oh    = '0;
    hit_rdata = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      if (bank_hit(req_addr, BASES[k], OFF_W)) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        hit_rdata = bank_rdata[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam string INIT_K = (k == 0) ? INIT_FILE0 :
                               (k == 1) ? INIT_FILE1 :
                               (k == 2) ? INIT_FILE2 : INIT_FILE3;
    logic we_k;

    // The write commits on the accept edge itself; reset suppresses it.
    assign we_k = accept & req_write & sel_oh[k] & ~reset;

    mem_bank #(
      .BANK_BYTES (BANK_BYTES),
      .INIT_FILE  (INIT_K)
    ) u_bank (
      .clk    (clk),
      .we     (we_k),
      .offset (req_addr[OFF_W-1:0]),
      .wdata  (req_wdata),
      .be     (req_be),
      .rdata  (bank_rdata[k])
    );
  end

  // State, counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state: capture the read word at accept, count wait states, hold until consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = (hit && !req_write) ? hit_rdata : 32'd0;
          err_d   = ~hit;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Counter value 1 marks the last wait cycle.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ERR_LOG_EN
  logic        err_sticky_q;
  logic [31:0] err_addr_q;

  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

  // Keep the address of the first unmapped access since reset; report every one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else if (accept && !hit) begin
      if (!err_sticky_q) begin
        err_sticky_q <= 1'b1;
        err_addr_q   <= req_addr;
      end
      $display("banked_sync_mem: unmapped access at address %h", req_addr);
    end
  end
`endif

endmodule

// File: tb/tb_banked_sync_mem.sv
// Bench for banked_sync_mem: three instances with 0, 3 and 5 wait states.
// Directed cases plus random traffic against a byte-array reference model.
module tb_banked_sync_mem;

  localparam int ND = 3;
  localparam int WCYC [ND] = '{0, 3, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_write [ND];
  logic [31:0] req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic [3:0]  req_be    [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [31:0] rsp_rdata [ND];
  logic        rsp_err   [ND];

  banked_sync_mem #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  banked_sync_mem #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  banked_sync_mem #(.WAIT_CYCLES(5)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: per instance, two 256-byte banks in address order.
  logic [7:0] mdl [ND][2][256];

  function automatic int mdl_bank(input logic [31:0] a);
    if (a / 256 == 32'h0000_0000 / 256) return 0;
    if (a / 256 == 32'h8000_0000 / 256) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
    int b;
    int o;
    b = mdl_bank(a);
    o = int'(a % 256) - int'(a % 4);
    if (b < 0) return 32'd0;
    return {mdl[d][b][o], mdl[d][b][o+1], mdl[d][b][o+2], mdl[d][b][o+3]};
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
    int b;
    int o;
    logic [31:0] w;
    b = mdl_bank(a);
    o = int'(a % 256) - int'(a % 4);
    w = wd;
    if (b >= 0) begin
      for (int i = 0; i < 4; i++) begin
        if (be[3-i]) mdl[d][b][o+i] = w[31-8*i -: 8];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response on instance d, consumer stalls 'hold' cycles.
  task automatic txn(input int d, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          k;
    exp_err = (mdl_bank(a) < 0);
    exp_rd  = (wr || exp_err) ? 32'd0 : mdl_read(d, a);
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("req_ready_before", {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a;
    req_wdata[d] = wd;   req_be[d]    = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_write[d] = 1'b0;
    req_addr[d]  = $urandom; req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    if (wr) mdl_write(d, a, wd, be);
    k = 1;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      chk("req_ready_busy", {31'd0, req_ready[d]}, 32'd0);
      @(posedge clk); #1; k++;
    end
    chk("latency", 32'(k), 32'(1 + WCYC[d]));
    chk("rsp_valid", {31'd0, rsp_valid[d]}, 32'd1);
    chk("rsp_rdata", rsp_rdata[d], exp_rd);
    chk("rsp_err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_rd);
      chk("hold_err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
      chk("hold_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("ready_after_hs", {31'd0, req_ready[d]}, 32'd1);
    chk("valid_after_hs", {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  byte_obs;
    int          r;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_be[d]    = '0;   rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
    end

    // Give instance 0 fully known contents.
    for (int b = 0; b < 2; b++) begin
      for (int o = 0; o < 64; o++) begin
        txn(0, 1'b1, (b == 0 ? 32'h0000_0000 : 32'h8000_0000) + 32'(o * 4), 32'd0, 4'hF, 0);
      end
    end

    // Full write, read back, check big-endian byte placement.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 0);
    byte_obs = dut0.g_bank[0].u_bank.mem_q[16];
    chk("byte_0x10", {24'd0, byte_obs}, 32'h0000_00DE);

    // Partial byte enables on bank 1; bank 0 at the same offset untouched.
    txn(0, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'hF, 0);
    txn(0, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'b0101, 0);
    txn(0, 1'b0, 32'h8000_0004, 32'd0, 4'h0, 1);
    txn(0, 1'b0, 32'h0000_0004, 32'd0, 4'h0, 0);

    // Unmapped read and write.
    txn(0, 1'b0, 32'h1234_0000, 32'd0, 4'hF, 0);
    txn(0, 1'b1, 32'h5000_0000, 32'hFFFF_FFFF, 4'hF, 0);

    // Write with no byte enables.
    txn(0, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'h0, 0);
    txn(0, 1'b0, 32'h0000_0020, 32'd0, 4'hF, 0);

    // Unaligned read returns the containing word.
    txn(0, 1'b1, 32'h0000_00FC, 32'h0102_0304, 4'hF, 0);
    txn(0, 1'b0, 32'h0000_00FE, 32'd0, 4'hF, 0);

    // Random traffic across both banks and unmapped space.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 4);
      if (r <= 1)      a = 32'h0000_0000 + 32'($urandom_range(0, 255));
      else if (r <= 3) a = 32'h8000_0000 + 32'($urandom_range(0, 255));
      else             a = {2'b01, 30'($urandom)};
      txn(0, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    // Three wait states with the consumer stalling five cycles.
    txn(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0);
    txn(1, 1'b0, 32'h8000_0010, 32'd0, 4'hF, 5);

    // Reset during the wait phase of a write.
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h0000_0040;
    req_wdata[2] = 32'h5A5A_A5A5; req_be[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0; req_write[2] = 1'b0;
    mdl_write(2, 32'h0000_0040, 32'h5A5A_A5A5, 4'hF);
    repeat (2) begin
      @(posedge clk); #1;
      chk("wait_valid", {31'd0, rsp_valid[2]}, 32'd0);
      chk("wait_ready", {31'd0, req_ready[2]}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_ready", {31'd0, req_ready[2]}, 32'd1);
    chk("post_rst_valid", {31'd0, rsp_valid[2]}, 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", {31'd0, rsp_valid[2]}, 32'd0);
    end
    txn(2, 1'b0, 32'h0000_0040, 32'd0, 4'hF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
